// File: rtl/openframe_gpio_ctrl.sv
// Openframe GPIO pad-control engine: shadow/active 12-bit config banks with a staggered apply.
// Optional cfg_lock port and write/apply lock are built only with OPENFRAME_GPIO_LOCK_EN defined.
module openframe_gpio_ctrl #(
  parameter int NUM_PADS      = 44,
  parameter int PADS_PER_STEP = 4,
  parameter int AW            = 6
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [11:0]         cfg_wdata,
  output logic                cfg_rvalid,
  output logic [11:0]         cfg_rdata,
  output logic                cfg_err,
  input  logic                apply_req,
`ifdef OPENFRAME_GPIO_LOCK_EN
  input  logic                cfg_lock,
`endif
  output logic                apply_busy,
  output logic                apply_done,
  input  logic [NUM_PADS-1:0] user_out,
  input  logic [NUM_PADS-1:0] user_oeb,
  output logic [NUM_PADS-1:0] gpio_out,
  output logic [NUM_PADS-1:0] gpio_oeb,
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm0,
  output logic [NUM_PADS-1:0] gpio_inp_dis,
  output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
  output logic [NUM_PADS-1:0] gpio_vtrip_sel,
  output logic [NUM_PADS-1:0] gpio_slow_sel,
  output logic [NUM_PADS-1:0] gpio_holdover,
  output logic [NUM_PADS-1:0] gpio_analog_en,
  output logic [NUM_PADS-1:0] gpio_analog_sel,
  output logic [NUM_PADS-1:0] gpio_analog_pol
);

  localparam logic [11:0] DEFAULT_WORD = 12'h801;
  localparam int          IW           = $clog2(NUM_PADS + PADS_PER_STEP + 1);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t        state;
  logic [IW-1:0] step;
  logic [11:0]   shadow [NUM_PADS];
  logic [11:0]   active [NUM_PADS];
  logic [11:0]   rd_word;
  logic          locked;
  logic          accept;
  logic          addr_ok;
  logic          do_write;
  logic          start_apply;
  logic          last_step;

  assign cfg_ready   = (state == IDLE);
  assign accept      = cfg_valid && cfg_ready;
  assign addr_ok     = ({1'b0, cfg_addr} < (AW+1)'(NUM_PADS));
  assign do_write    = accept && cfg_we && addr_ok && !locked;
  assign start_apply = (state == IDLE) && apply_req && !locked;
  assign last_step   = (step + IW'(PADS_PER_STEP)) >= IW'(NUM_PADS);

`ifdef OPENFRAME_GPIO_LOCK_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)       locked <= 1'b0;
    else if (cfg_lock) locked <= 1'b1;
  end
`else
  assign locked = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (cfg_addr == AW'(p)) rd_word = shadow[p];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      step       <= '0;
      apply_busy <= 1'b0;
      apply_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_apply) begin
            state      <= APPLY;
            step       <= '0;
            apply_busy <= 1'b1;
          end
        end
        APPLY: begin
          step <= step + IW'(PADS_PER_STEP);
          if (last_step) begin
            state      <= DONE;
            apply_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          apply_busy <= 1'b0;
          apply_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          apply_busy <= 1'b0;
          apply_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_rvalid <= accept && !cfg_we;
      if (accept && !cfg_we) cfg_rdata <= rd_word;
      if (accept && (!addr_ok || (cfg_we && locked))) cfg_err <= 1'b1;
    end
  end

  // NOTE: both banks are reset explicitly; a pad must never power up with an unknown mode.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int p = 0; p < NUM_PADS; p++) shadow[p] <= DEFAULT_WORD;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (do_write && cfg_addr == AW'(p)) shadow[p] <= cfg_wdata;
      end
    end
  end

  // Each APPLY cycle copies the window [step, step+PADS_PER_STEP); pads past the end do not exist.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int p = 0; p < NUM_PADS; p++) active[p] <= DEFAULT_WORD;
    end else if (state == APPLY) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (IW'(p) >= step && IW'(p) < step + IW'(PADS_PER_STEP)) active[p] <= shadow[p];
      end
    end
  end

  assign gpio_out = user_out;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    assign gpio_dm0[p]         = active[p][0];
    assign gpio_dm1[p]         = active[p][1];
    assign gpio_dm2[p]         = active[p][2];
    assign gpio_inp_dis[p]     = active[p][3];
    assign gpio_ib_mode_sel[p] = active[p][4];
    assign gpio_vtrip_sel[p]   = active[p][5];
    assign gpio_slow_sel[p]    = active[p][6];
    assign gpio_holdover[p]    = active[p][7];
    assign gpio_analog_en[p]   = active[p][8];
    assign gpio_analog_sel[p]  = active[p][9];
    assign gpio_analog_pol[p]  = active[p][10];
    assign gpio_oeb[p]         = user_oeb[p] | active[p][11];
  end

endmodule

// File: tb/tb_openframe_gpio_ctrl.sv
// Self-checking bench for openframe_gpio_ctrl: a 44-pad/4-step instance with a read-data
// scoreboard, and a 10-pad/4-step instance exercising the partial final step.
module tb_openframe_gpio_ctrl;

  localparam int NP = 44, PPS = 4, AW = 6, STEPS = (NP + PPS - 1) / PPS;
  localparam int SNP = 10, SAW = 4, SSTEPS = (SNP + PPS - 1) / PPS;
  localparam logic [11:0] DEF = 12'h801;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb;
  logic cfg_valid, cfg_ready, cfg_we, cfg_rvalid, cfg_err, apply_req, apply_busy, apply_done;
  logic [AW-1:0] cfg_addr;
  logic [11:0] cfg_wdata, cfg_rdata;
  logic [NP-1:0] user_out, user_oeb, gpio_out, gpio_oeb, gpio_dm2, gpio_dm1, gpio_dm0;
  logic [NP-1:0] gpio_inp_dis, gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel, gpio_holdover;
  logic [NP-1:0] gpio_analog_en, gpio_analog_sel, gpio_analog_pol;
`ifdef OPENFRAME_GPIO_LOCK_EN
  logic cfg_lock;
`endif

  logic s_valid, s_ready, s_we, s_rvalid, s_err, s_apply_req, s_busy, s_done;
  logic [SAW-1:0] s_addr;
  logic [11:0] s_wdata, s_rdata;
  logic [SNP-1:0] s_user_out, s_user_oeb, s_out, s_oeb, s_dm2, s_dm1, s_dm0;
  logic [SNP-1:0] s_inp_dis, s_ib, s_vtrip, s_slow, s_hold, s_an_en, s_an_sel, s_an_pol;

  int checks = 0;
  int errors = 0;
  logic [11:0] sh [NP];
  logic [11:0] act [NP];
  logic [11:0] s_sh [SNP];
  logic [11:0] s_act [SNP];
  logic [11:0] exp_q [$];
  logic [11:0] mon_exp;

  openframe_gpio_ctrl #(.NUM_PADS(NP), .PADS_PER_STEP(PPS), .AW(AW)) dut (
    .clk(clk), .resetb(resetb), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
    .cfg_err(cfg_err), .apply_req(apply_req),
`ifdef OPENFRAME_GPIO_LOCK_EN
    .cfg_lock(cfg_lock),
`endif
    .apply_busy(apply_busy), .apply_done(apply_done), .user_out(user_out), .user_oeb(user_oeb),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .gpio_dm2(gpio_dm2), .gpio_dm1(gpio_dm1),
    .gpio_dm0(gpio_dm0), .gpio_inp_dis(gpio_inp_dis), .gpio_ib_mode_sel(gpio_ib_mode_sel),
    .gpio_vtrip_sel(gpio_vtrip_sel), .gpio_slow_sel(gpio_slow_sel), .gpio_holdover(gpio_holdover),
    .gpio_analog_en(gpio_analog_en), .gpio_analog_sel(gpio_analog_sel),
    .gpio_analog_pol(gpio_analog_pol)
  );

  openframe_gpio_ctrl #(.NUM_PADS(SNP), .PADS_PER_STEP(PPS), .AW(SAW)) dut_small (
    .clk(clk), .resetb(resetb), .cfg_valid(s_valid), .cfg_ready(s_ready), .cfg_we(s_we),
    .cfg_addr(s_addr), .cfg_wdata(s_wdata), .cfg_rvalid(s_rvalid), .cfg_rdata(s_rdata),
    .cfg_err(s_err), .apply_req(s_apply_req),
`ifdef OPENFRAME_GPIO_LOCK_EN
    .cfg_lock(1'b0),
`endif
    .apply_busy(s_busy), .apply_done(s_done), .user_out(s_user_out), .user_oeb(s_user_oeb),
    .gpio_out(s_out), .gpio_oeb(s_oeb), .gpio_dm2(s_dm2), .gpio_dm1(s_dm1), .gpio_dm0(s_dm0),
    .gpio_inp_dis(s_inp_dis), .gpio_ib_mode_sel(s_ib), .gpio_vtrip_sel(s_vtrip),
    .gpio_slow_sel(s_slow), .gpio_holdover(s_hold), .gpio_analog_en(s_an_en),
    .gpio_analog_sel(s_an_sel), .gpio_analog_pol(s_an_pol)
  );

  function automatic logic [13*NP-1:0] pads_obs();
    return {gpio_out, gpio_oeb, gpio_dm2, gpio_dm1, gpio_dm0, gpio_inp_dis, gpio_ib_mode_sel,
            gpio_vtrip_sel, gpio_slow_sel, gpio_holdover, gpio_analog_en, gpio_analog_sel,
            gpio_analog_pol};
  endfunction

  function automatic logic [13*NP-1:0] pads_exp();
    logic [NP-1:0] v [13];
    for (int p = 0; p < NP; p++) begin
      v[0][p] = user_out[p];
      v[1][p] = user_oeb[p] | act[p][11];
      v[2][p] = act[p][2];
      v[3][p] = act[p][1];
      v[4][p] = act[p][0];
      for (int b = 3; b <= 10; b++) v[b+2][p] = act[p][b];
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], v[8], v[9], v[10], v[11], v[12]};
  endfunction

  function automatic logic [13*SNP-1:0] s_pads_obs();
    return {s_out, s_oeb, s_dm2, s_dm1, s_dm0, s_inp_dis, s_ib, s_vtrip, s_slow, s_hold,
            s_an_en, s_an_sel, s_an_pol};
  endfunction

  function automatic logic [13*SNP-1:0] s_pads_exp();
    logic [SNP-1:0] v [13];
    for (int p = 0; p < SNP; p++) begin
      v[0][p] = s_user_out[p];
      v[1][p] = s_user_oeb[p] | s_act[p][11];
      v[2][p] = s_act[p][2];
      v[3][p] = s_act[p][1];
      v[4][p] = s_act[p][0];
      for (int b = 3; b <= 10; b++) v[b+2][p] = s_act[p][b];
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], v[8], v[9], v[10], v[11], v[12]};
  endfunction

  // Read-data scoreboard: every accepted read pushes its expected word; each rvalid pops one.
  always @(negedge clk) begin
    if (resetb === 1'b1 && cfg_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rvalid with rdata %h, none expected", cfg_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cfg_rdata !== mon_exp) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", cfg_rdata, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    for (int p = 0; p < NP; p++) begin sh[p] = DEF; act[p] = DEF; end
    for (int p = 0; p < SNP; p++) begin s_sh[p] = DEF; s_act[p] = DEF; end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && cfg_ready !== 1'b1; i++) @(negedge clk);
    if (cfg_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cfg_ready %b expected 1", cfg_ready);
    end
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [11:0] d);
    wait_idle();
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_we = 1'b0;
    if (int'(a) < NP) sh[a] = d;
  endtask

  task automatic cfg_read(input logic [AW-1:0] a);
    wait_idle();
    exp_q.push_back(int'(a) < NP ? sh[a] : 12'h000);
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_rvalid !== 1'b1) begin
      errors++; $display("FAIL rvalid_latency addr %0d: got %b expected 1", a, cfg_rvalid);
    end
    @(negedge clk);
    checks++;
    if (cfg_rvalid !== 1'b0) begin
      errors++; $display("FAIL rvalid_pulse addr %0d: got %b expected 0", a, cfg_rvalid);
    end
  endtask

  task automatic check_pads(input string tag);
    checks++;
    if (pads_obs() !== pads_exp()) begin
      errors++; $display("FAIL %s: pads got %h expected %h", tag, pads_obs(), pads_exp());
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    cfg_valid = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; apply_req = 0;
    user_out = NP'({$urandom(), $urandom()}); user_oeb = '1;
    s_valid = 0; s_we = 0; s_addr = '0; s_wdata = '0; s_apply_req = 0;
    s_user_out = '0; s_user_oeb = '0;
`ifdef OPENFRAME_GPIO_LOCK_EN
    cfg_lock = 1'b0;
`endif
    reset_model();
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    check_pads("reset_pads");
    checks++;
    if ({apply_busy, apply_done, cfg_err, cfg_rvalid, cfg_ready} !== 5'b00001 || cfg_rdata !== 12'h0) begin
      errors++;
      $display("FAIL reset_status: busy/done/err/rvalid/ready %b rdata %h expected 00001 000",
               {apply_busy, apply_done, cfg_err, cfg_rvalid, cfg_ready}, cfg_rdata);
    end
  endtask

  task automatic test_write_read();
    cfg_write(6'd5, 12'h006);
    check_pads("shadow_write_no_pad_change");
    cfg_read(6'd5);
    cfg_read(6'd0);
    cfg_write(6'd43, 12'h5F8);
    cfg_read(6'd43);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b expected 0", cfg_err); end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    for (int i = 8; i < 16; i++) begin
      cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = AW'(i); cfg_wdata = 12'($urandom());
      sh[i] = cfg_wdata;
      @(negedge clk);
    end
    for (int i = 8; i < 16; i++) begin
      cfg_we = 1'b0; cfg_addr = AW'(i);
      exp_q.push_back(sh[i]);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    @(negedge clk);
    check_pads("burst_no_pad_change");
  endtask

  task automatic test_out_of_range();
    cfg_write(6'd50, 12'hFFF);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected 1", cfg_err); end
    cfg_read(6'd50);
    cfg_write(6'd1, 12'h030);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", cfg_err); end
    cfg_read(6'd5);
  endtask

  task automatic run_apply(input bit with_write, input logic [AW-1:0] wa, input logic [11:0] wd,
                           input int extra_at, input string tag);
    int busy_cnt, done_cnt, done_at, stray;
    busy_cnt = 0; done_cnt = 0; done_at = 0; stray = 0;
    wait_idle();
    if (with_write) begin
      cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = wa; cfg_wdata = wd; sh[wa] = wd;
    end
    apply_req = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k <= STEPS + 1; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k <= STEPS)
          for (int p = (k - 1) * PPS; p < k * PPS && p < NP; p++) act[p] = sh[p];
      end
      apply_req = (k == extra_at);
      if (apply_busy === 1'b1) busy_cnt++;
      if (apply_done === 1'b1) begin done_cnt++; done_at = busy_cnt; end
      check_pads($sformatf("%s_step%0d", tag, k));
    end
    apply_req = 1'b0;
    checks++;
    if (busy_cnt != STEPS + 1 || done_cnt != 1 || done_at != STEPS + 1) begin
      errors++;
      $display("FAIL %s_timing: busy %0d done %0d done_at %0d expected %0d 1 %0d",
               tag, busy_cnt, done_cnt, done_at, STEPS + 1, STEPS + 1);
    end
    repeat (10) begin
      @(negedge clk);
      if (apply_busy !== 1'b0 || apply_done !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL %s_requeue: %0d busy cycles expected 0", tag, stray); end
  endtask

  task automatic test_apply();
    user_oeb = '1; user_oeb[5] = 1'b0;
    run_apply(1'b0, '0, '0, -1, "apply");
    checks++;
    if ({gpio_dm2[5], gpio_dm1[5], gpio_dm0[5], gpio_oeb[5]} !== 4'b1100) begin
      errors++;
      $display("FAIL pad5_mode: dm/oeb got %b expected 1100",
               {gpio_dm2[5], gpio_dm1[5], gpio_dm0[5], gpio_oeb[5]});
    end
  endtask

  task automatic test_write_with_apply();
    run_apply(1'b1, 6'd0, 12'h0A2, 3, "same_cycle");
  endtask

  task automatic test_small_partial();
    int busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < SNP; i++) begin
      s_valid = 1'b1; s_we = 1'b1; s_addr = SAW'(i); s_wdata = 12'($urandom()); s_sh[i] = s_wdata;
      @(negedge clk);
    end
    s_valid = 1'b0; s_we = 1'b0; s_apply_req = 1'b1;
    @(negedge clk);
    s_apply_req = 1'b0;
    for (int k = 0; k <= SSTEPS + 1; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k <= SSTEPS)
          for (int p = (k - 1) * PPS; p < k * PPS && p < SNP; p++) s_act[p] = s_sh[p];
      end
      if (s_busy === 1'b1) busy_cnt++;
      if (s_done === 1'b1) done_cnt++;
      checks++;
      if (s_pads_obs() !== s_pads_exp()) begin
        errors++; $display("FAIL small_step%0d: pads got %h expected %h", k, s_pads_obs(), s_pads_exp());
      end
    end
    checks++;
    if (busy_cnt != SSTEPS + 1 || done_cnt != 1) begin
      errors++; $display("FAIL small_timing: busy %0d done %0d expected %0d 1", busy_cnt, done_cnt, SSTEPS + 1);
    end
    s_valid = 1'b1; s_we = 1'b0; s_addr = 4'd3;
    @(negedge clk);
    s_addr = 4'd12; s_we = 1'b1; s_wdata = 12'h3C3;
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== s_sh[3]) begin
      errors++; $display("FAIL small_read3: rvalid %b rdata %h expected 1 %h", s_rvalid, s_rdata, s_sh[3]);
    end
    @(negedge clk);
    s_we = 1'b0;
    checks++;
    if (s_err !== 1'b1) begin errors++; $display("FAIL small_oor_err: got %b expected 1", s_err); end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 12'h000) begin
      errors++; $display("FAIL small_read12: rvalid %b rdata %h expected 1 000", s_rvalid, s_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_apply();
    cfg_write(6'd20, 12'h7FE);
    apply_req = 1'b1;
    @(negedge clk);
    apply_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetb = 1'b0;
    #1;
    reset_model();
    check_pads("async_reset_pads");
    checks++;
    if ({apply_busy, apply_done, cfg_err, cfg_rvalid} !== 4'b0000 || cfg_rdata !== 12'h0) begin
      errors++;
      $display("FAIL async_reset_status: busy/done/err/rvalid %b rdata %h expected 0000 000",
               {apply_busy, apply_done, cfg_err, cfg_rvalid}, cfg_rdata);
    end
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    cfg_read(6'd20);
  endtask

`ifdef OPENFRAME_GPIO_LOCK_EN
  task automatic test_lock();
    int stray;
    stray = 0;
    cfg_lock = 1'b1;
    @(negedge clk);
    cfg_lock = 1'b0;
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd7; cfg_wdata = 12'h123;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL lock_err: got %b expected 1", cfg_err); end
    cfg_read(6'd7);
    apply_req = 1'b1;
    @(negedge clk);
    apply_req = 1'b0;
    repeat (5) begin
      if (apply_busy !== 1'b0) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL lock_apply: %0d busy cycles expected 0", stray); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_apply();
    test_write_with_apply();
    test_small_partial();
    test_reset_mid_apply();
`ifdef OPENFRAME_GPIO_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rd_missing: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/openframe_gpio_ctrl.md
Name: openframe_gpio_ctrl

Overview:
- Parametrised pad-control engine between an openframe user project and its NUM_PADS GPIO pads.
- Holds a per-pad 12-bit configuration in a shadow bank written over a valid/ready register port.
- On request, copies shadow to the active bank PADS_PER_STEP pads per cycle, so pad-mode changes are staggered rather than simultaneous.
- Drives every static pad control vector from the active bank and merges user output-enable with a per-pad forced-off bit.

Parameters:
- NUM_PADS, 44, number of GPIO pads controlled (1..64).
- PADS_PER_STEP, 4, pads updated per cycle during apply (1..NUM_PADS).
- AW, 6, cfg_addr width; must satisfy 2^AW >= NUM_PADS.

Ports:
- clk  input  1  core clock.
- resetb  input  1  asynchronous active-low reset.
- cfg_valid  input  1  register access request.
- cfg_ready  output  1  access accepted when cfg_valid && cfg_ready.
- cfg_we  input  1  1 = write shadow, 0 = read shadow.
- cfg_addr  input  AW  pad index.
- cfg_wdata  input  12  configuration word.
- cfg_rvalid  output  1  one-cycle pulse, read data valid.
- cfg_rdata  output  12  shadow word read.
- cfg_err  output  1  sticky out-of-range or locked-access flag.
- apply_req  input  1  start shadow-to-active copy.
- apply_busy  output  1  copy in progress.
- apply_done  output  1  one-cycle pulse at copy completion.
- user_out  input  NUM_PADS  user output data.
- user_oeb  input  NUM_PADS  user output enable, active low.
- gpio_out  output  NUM_PADS  equals user_out (combinational).
- gpio_oeb  output  NUM_PADS  user_oeb OR active oeb_force bit.
- gpio_dm2, gpio_dm1, gpio_dm0, gpio_inp_dis, gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel, gpio_holdover, gpio_analog_en, gpio_analog_sel, gpio_analog_pol  output  NUM_PADS each  registered from the active bank.
- cfg_lock  input  1  present only with OPENFRAME_GPIO_LOCK_EN.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, resetb.
- Config word layout: [2:0] dm, [3] inp_dis, [4] ib_mode_sel, [5] vtrip_sel, [6] slow_sel, [7] holdover, [8] analog_en, [9] analog_sel, [10] analog_pol, [11] oeb_force.
- Reset default word: 12'h801, i.e. dm=001 (input only), oeb_force=1, all other bits 0.
- Reset values:
  - Shadow and active banks load the default word in every entry.
  - Result: gpio_dm0 all 1, gpio_dm2/dm1 all 0, gpio_oeb all 1, all other pad control vectors 0.
  - cfg_rvalid=0, cfg_rdata=0, cfg_err=0, apply_busy=0, apply_done=0, state IDLE.
- FSM states: IDLE, APPLY, DONE.
  - cfg_ready = (state==IDLE).
  - IDLE -> APPLY on apply_req. Step index is cleared to 0.
  - APPLY: each cycle copies shadow[i .. i+PADS_PER_STEP-1] to active; i += PADS_PER_STEP.
  - The final step is partial if NUM_PADS is not a multiple of PADS_PER_STEP; no write occurs beyond NUM_PADS-1.
  - After the step covering pad NUM_PADS-1, go to DONE.
  - DONE: apply_done=1 for exactly one cycle, then IDLE.
  - apply_busy = (state != IDLE).
  - Apply duration: ceil(NUM_PADS/PADS_PER_STEP) APPLY cycles plus 1 DONE cycle.
- Register access (in IDLE only):
  - Write: shadow[cfg_addr] updates at the accepting edge.
  - Read: cfg_rdata and cfg_rvalid are registered, one cycle after acceptance.
  - cfg_addr >= NUM_PADS: access is accepted and discarded, cfg_err sets; a read returns 0 with cfg_rvalid=1.
  - cfg_err clears only on reset.
- Simultaneous write and apply_req in IDLE: the write commits first, and the copy includes it.
- apply_req during APPLY or DONE is ignored; it is not queued.
- Pad outputs change only when the active bank changes; shadow writes alone never change them.
- Reset asserted mid-apply: both banks return to the default word immediately; no partial state is retained.

Optional Feature:
- Macro: OPENFRAME_GPIO_LOCK_EN.
- With the macro: a cfg_lock port is added, sampled each cycle.
  - Once seen high, an internal lock bit sets and stays set until reset.
  - While locked: writes are accepted but discarded and set cfg_err; reads behave normally; apply_req is ignored.
  - A lock rising during APPLY lets the current copy finish.
- Without the macro: no cfg_lock port, no lock logic, and writes and applies are always permitted.

Test Plan:
- Reset release -> gpio_oeb all 1s, gpio_dm0 all 1s, every other pad control vector 0, apply_busy=0, cfg_err=0.
- Write pad 5 = 12'h006 (dm=110, oeb_force=0), then read pad 5 -> cfg_rvalid one cycle after acceptance, cfg_rdata=12'h006; gpio_dm* for pad 5 unchanged until apply.
- Issue apply_req with NUM_PADS=44, PADS_PER_STEP=4:
  - Expect apply_busy for 12 cycles and apply_done once on the 12th.
  - Pads 4-7 update on the 2nd APPLY edge; pad 5 then shows dm=110.
  - With user_oeb[5]=0, gpio_oeb[5]=0.
- Configure NUM_PADS=10, PADS_PER_STEP=4 -> 3 APPLY cycles, last step writes only pads 8-9; write to addr 12 sets cfg_err, and a read of addr 12 returns 0.
- Assert write to pad 0 and apply_req in the same IDLE cycle -> copy includes the new pad 0 value. A second apply_req during APPLY is ignored, giving a single apply_done.
- Assert resetb low during APPLY step 3 -> all outputs return to reset values asynchronously. With OPENFRAME_GPIO_LOCK_EN: after a cfg_lock pulse, a write sets cfg_err, shadow is unchanged, and apply_req gives no apply_busy.
